// File: rtl/pipe_skid_stage_pkg.sv
// Shared CPU pipeline definitions: stage occupancy states and default
// payload widths used by the ID/EX, EX/MEM and MEM/WB skid stages.
package pipe_skid_stage_pkg;

  // Default payload widths; each pipeline stage overrides them as needed.
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CTRL_W = 9;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Number of entries held in a given state.
  function automatic logic [1:0] occupancy_of(input skid_state_e st);
    return logic'(st == ST_FULL) ? 2'd2 : (st == ST_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage. A main register drives the outputs
// and a skid register absorbs the one-cycle lag of the registered in_ready,
// so upstream never sees a combinational path from out_ready.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  skid_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q;
  logic              in_ready_d;
  logic              accept;
  logic              issue;

  // Handshake qualifiers; in_ready comes straight from its own flop.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign issue     = out_valid & out_ready;

  // The main register is zeroed whenever it becomes empty, so it can drive
  // the payload outputs directly and bubbles carry all-zero control.
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occupancy_of(state_q);

  // Next-state and next-payload selection.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end

      ST_ONE: begin
        if (accept && issue) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          state_d     = ST_FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (issue) begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          main_data_d = '0;
        end
      end

      ST_FULL: begin
        // in_ready is low here, so only an issue can change anything.
        if (issue) begin
          state_d     = ST_ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
      end

      default: begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
        main_data_d = '0;
        skid_ctrl_d = '0;
        skid_data_d = '0;
      end
    endcase

    // Flush squashes everything, including an entry accepted this cycle.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end

    // Ready for the next cycle is decided from the next state, never from out_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  // State, payload and ready registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: both payload registers are reset, not just the state, because the
    // outputs must read zero immediately and the skid must hold no stale entry.
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a random
// handshake run, all checked against a FIFO-queue reference model.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the entries held, oldest first.
  logic [CTRL_W+DATA_W-1:0] model_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model's current contents.
  task automatic check_outputs(input string tag);
    logic [CTRL_W+DATA_W-1:0] head;
    int sz;
    sz   = model_q.size();
    head = (sz > 0) ? model_q[0] : '0;
    check({tag, " out_valid"}, 64'(out_valid), 64'(sz > 0));
    check({tag, " in_ready"},  64'(in_ready),  64'(sz < 2));
    check({tag, " occupancy"}, 64'(occupancy), 64'(sz));
    check({tag, " out_ctrl"},  64'(out_ctrl),  64'(head[CTRL_W+DATA_W-1:DATA_W]));
    check({tag, " out_data"},  64'(out_data),  64'(head[DATA_W-1:0]));
  endtask

  // One clock cycle: check at the falling edge, drive inputs, then let the
  // model follow the handshakes the rules imply at the rising edge.
  task automatic cycle(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    logic acc, iss;
    @(negedge clk);
    check_outputs(tag);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = v && (model_q.size() < 2);
    iss = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (iss) void'(model_q.pop_front());
      if (acc) model_q.push_back({c, d});
    end
  endtask

  task automatic idle(input string tag, input logic ordy, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state while rst is held.
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++)
      cycle("stream", 1'b1, CTRL_W'(i + 16), DATA_W'(i), 1'b1, 1'b0);
    idle("drain", 1'b1, 2);

    // Fill with 0xA, 0xB under backpressure, hold, then drain.
    cycle("fill", 1'b1, 9'h1AA, 32'hA, 1'b0, 1'b0);
    cycle("fill", 1'b1, 9'h1BB, 32'hB, 1'b0, 1'b0);
    // This offer arrives while the stage is full and must be ignored.
    cycle("full_ignore", 1'b1, 9'h1EE, 32'hE, 1'b0, 1'b0);
    idle("hold", 1'b0, 2);
    idle("unstall", 1'b1, 3);

    // Flush while full, with a simultaneous offer of 0xC.
    cycle("refill", 1'b1, 9'h101, 32'h1, 1'b0, 1'b0);
    cycle("refill", 1'b1, 9'h102, 32'h2, 1'b0, 1'b0);
    cycle("flush", 1'b1, 9'h1CC, 32'hC, 1'b0, 1'b1);
    idle("post_flush", 1'b1, 3);

    // Randomised handshakes against the model.
    for (int i = 0; i < 1000; i++)
      cycle("random", ($urandom_range(0, 9) < 6), CTRL_W'($urandom), DATA_W'($urandom),
            ($urandom_range(0, 9) < 6), 1'b0);
    idle("random_drain", 1'b1, 3);

    // Asynchronous reset mid-operation while full.
    cycle("pre_rst", 1'b1, 9'h111, 32'h11, 1'b0, 1'b0);
    cycle("pre_rst", 1'b1, 9'h122, 32'h22, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs("full_before_rst");
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("after_rst", 1'b1, 9'h055, 32'h5, 1'b1, 1'b0);
    idle("after_rst_drain", 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
